// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data access.
// Alternating priority on contention; fixed MEM_LATENCY strobe cycles per access.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] if_rdata,
    output logic [31:0] dm_rdata,
    output logic        if_valid,
    output logic        dm_valid,
    output logic        pc_hold,
    output logic        pipe_hold
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       last_grant;

    logic       if_pend;
    logic       dm_pend;
    logic       grant_dm;
    logic       grant_if;

    // A requester whose valid is high this cycle is finishing, not asking again.
    assign if_pend  = if_req & ~if_valid;
    assign dm_pend  = (dm_read | dm_write) & ~dm_valid;
    assign grant_dm = dm_pend & (~if_pend | ~last_grant);
    assign grant_if = if_pend & ~grant_dm;

    assign pipe_hold = (dm_read | dm_write) & ~dm_valid;
    assign pc_hold   = pipe_hold | (if_req & ~if_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            last_grant <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            if_rdata   <= 32'd0;
            dm_rdata   <= 32'd0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state      <= DATA;
                        cnt        <= CNT_INIT;
                        mem_addr   <= dm_addr;
                        last_grant <= 1'b1;
                        // A store wins when both load and store are raised.
                        if (dm_write) begin
                            mem_we    <= 1'b1;
                            mem_re    <= 1'b0;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_re <= 1'b1;
                            mem_we <= 1'b0;
                        end
                    end else if (grant_if) begin
                        state      <= FETCH;
                        cnt        <= CNT_INIT;
                        mem_addr   <= if_addr;
                        mem_re     <= 1'b1;
                        mem_we     <= 1'b0;
                        last_grant <= 1'b0;
                    end
                end
                DATA, FETCH: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        // mem_we still marks the in-flight access as a store here.
                        if (state == FETCH) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!mem_we) dm_rdata <= mem_rdata;
                            dm_valid <= 1'b1;
                        end
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance, MEM_LATENCY = 2
    logic        if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
    logic        mem_re, mem_we, if_valid, dm_valid, pc_hold, pipe_hold;

    // second instance, MEM_LATENCY = 1
    logic        if_req_b, dm_read_b, dm_write_b;
    logic [31:0] if_addr_b, dm_addr_b, dm_wdata_b, mem_rdata_b;
    logic [31:0] mem_addr_b, mem_wdata_b, if_rdata_b, dm_rdata_b;
    logic        mem_re_b, mem_we_b, if_valid_b, dm_valid_b, pc_hold_b, pipe_hold_b;

    logic        rd_ovr_en;
    logic [31:0] rd_ovr;

    function automatic logic [31:0] scramble(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    assign mem_rdata   = rd_ovr_en ? rd_ovr : scramble(mem_addr);
    assign mem_rdata_b = 32'h1234_5678;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .if_rdata(if_rdata), .dm_rdata(dm_rdata),
        .if_valid(if_valid), .dm_valid(dm_valid), .pc_hold(pc_hold), .pipe_hold(pipe_hold)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_req(if_req_b), .if_addr(if_addr_b),
        .dm_read(dm_read_b), .dm_write(dm_write_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
        .mem_rdata(mem_rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_re(mem_re_b), .mem_we(mem_we_b), .if_rdata(if_rdata_b), .dm_rdata(dm_rdata_b),
        .if_valid(if_valid_b), .dm_valid(dm_valid_b), .pc_hold(pc_hold_b), .pipe_hold(pipe_hold_b)
    );

    int n_pass = 0, n_fail = 0, n_total = 0;
    int cyc = 0;

    // Reference model: at most one access in flight; granted at t_start, strobes
    // t_start+1..t_start+L, completion pulse at t_start+L+1 (port free again then).
    int          free_at, t_start;
    bit          in_flight, t_data, t_wr, lg;
    logic [31:0] t_addr, t_wdata, e_if_rdata, e_dm_rdata;
    bit          e_if_valid, e_dm_valid, strobe;

    // requester drivers
    bit          rand_mode;
    int          if_want, dm_want;
    bit          if_act, dm_act, if_done, dm_done, if_gr, dm_gr;
    logic [1:0]  dm_kind, d_kind;
    logic [31:0] d_if_addr, d_dm_addr, d_wdata;
    logic        b_read_nxt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        in_flight  = 1'b0;
        free_at    = 0;
        lg         = 1'b0;
        e_if_rdata = 32'd0;
        e_dm_rdata = 32'd0;
        if_done    = 1'b0;
        dm_done    = 1'b0;
        if_gr      = 1'b0;
        dm_gr      = 1'b0;
    endtask

    task automatic drive();
        if (if_done) begin if_act = 1'b0; if_gr = 1'b0; end
        if (dm_done) begin dm_act = 1'b0; dm_gr = 1'b0; end
        if (!if_act && (rand_mode ? ($urandom_range(0, 2) != 0) : (if_want > 0))) begin
            if_act = 1'b1;
            if (!rand_mode) if_want--;
            if_addr = rand_mode ? ($urandom() & ~32'h3) : d_if_addr;
        end else if (rand_mode && if_gr && $urandom_range(0, 1) == 1) begin
            if_addr = $urandom();
        end
        if (!dm_act && (rand_mode ? ($urandom_range(0, 2) != 0) : (dm_want > 0))) begin
            dm_act = 1'b1;
            if (!rand_mode) dm_want--;
            dm_kind  = rand_mode ? 2'($urandom_range(1, 3)) : d_kind;
            dm_addr  = rand_mode ? ($urandom() & ~32'h3) : d_dm_addr;
            dm_wdata = rand_mode ? $urandom() : d_wdata;
        end else if (rand_mode && dm_gr && $urandom_range(0, 1) == 1) begin
            dm_addr  = $urandom();
            dm_wdata = $urandom();
        end
        if_req    = if_act;
        dm_read   = dm_act & dm_kind[0];
        dm_write  = dm_act & dm_kind[1];
        dm_read_b = b_read_nxt;
    endtask

    task automatic compute();
        e_if_valid = in_flight && !t_data && cyc == t_start + L + 1;
        e_dm_valid = in_flight && t_data && cyc == t_start + L + 1;
        if (e_if_valid) e_if_rdata = rd_ovr_en ? rd_ovr : scramble(t_addr);
        if (e_dm_valid && !t_wr) e_dm_rdata = rd_ovr_en ? rd_ovr : scramble(t_addr);
        strobe = in_flight && cyc > t_start && cyc <= t_start + L;
    endtask

    task automatic check();
        chk1("mem_re", mem_re, strobe && !t_wr);
        chk1("mem_we", mem_we, strobe && t_wr);
        if (strobe) chk32("mem_addr", mem_addr, t_addr);
        if (strobe && t_wr) chk32("mem_wdata", mem_wdata, t_wdata);
        chk1("if_valid", if_valid, e_if_valid);
        chk1("dm_valid", dm_valid, e_dm_valid);
        chk32("if_rdata", if_rdata, e_if_rdata);
        chk32("dm_rdata", dm_rdata, e_dm_rdata);
        chk1("pipe_hold", pipe_hold, (dm_read || dm_write) && !e_dm_valid);
        chk1("pc_hold", pc_hold, ((dm_read || dm_write) && !e_dm_valid) || (if_req && !e_if_valid));
    endtask

    task automatic grant();
        bit dm_p, if_p;
        dm_p = (dm_read || dm_write) && !e_dm_valid;
        if_p = if_req && !e_if_valid;
        if (cyc >= free_at && (dm_p || if_p)) begin
            // contention goes to whoever did not get the previous grant
            t_data    = dm_p && (!if_p || !lg);
            t_wr      = t_data && dm_write;
            t_addr    = t_data ? dm_addr : if_addr;
            t_wdata   = dm_wdata;
            t_start   = cyc;
            in_flight = 1'b1;
            free_at   = cyc + L + 1;
            lg        = t_data;
            if (t_data) dm_gr = 1'b1; else if_gr = 1'b1;
        end
        if_done = e_if_valid;
        dm_done = e_dm_valid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        compute();
        @(negedge clk);
        check();
        grant();
    endtask

    task automatic chk_regs_zero(input string tag);
        chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk1({tag, "_mem_re"}, mem_re, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk32({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk32({tag, "_dm_rdata"}, dm_rdata, 32'd0);
        chk1({tag, "_if_valid"}, if_valid, 1'b0);
        chk1({tag, "_dm_valid"}, dm_valid, 1'b0);
    endtask

    // Called right after a step: asserts reset mid-cycle, checks the asynchronous
    // clear, releases it after one edge and models that first IDLE cycle.
    task automatic mid_reset();
        #1 rst_n = 1'b0;
        #1 chk_regs_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        cyc++;
        drive();
        compute();
        @(negedge clk);
        check();
        grant();
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
        if_req_b = 1'b0; dm_read_b = 1'b0; dm_write_b = 1'b0;
        if_addr_b = 32'd0; dm_addr_b = 32'h0000_0200; dm_wdata_b = 32'd0;
        rd_ovr_en = 1'b0; rd_ovr = 32'd0;
        rand_mode = 1'b0; if_want = 0; dm_want = 0;
        if_act = 1'b0; dm_act = 1'b0; dm_kind = 2'b01; d_kind = 2'b01;
        d_if_addr = 32'd0; d_dm_addr = 32'd0; d_wdata = 32'd0; b_read_nxt = 1'b0;
        t_start = 0; t_data = 1'b0; t_wr = 1'b0; t_addr = 32'd0; t_wdata = 32'd0;
        model_reset();

        #8;
        chk_regs_zero("reset");
        chk32("reset_b_dm_rdata", dm_rdata_b, 32'd0);
        #4 rst_n = 1'b1;

        // single fetch with a fixed instruction word
        rd_ovr_en = 1'b1; rd_ovr = 32'h8C01_0004;
        d_if_addr = 32'h0000_0040; if_want = 1;
        repeat (5) step();
        chk32("fetch_word", if_rdata, 32'h8C01_0004);
        rd_ovr_en = 1'b0;

        // simultaneous load and fetch straight after reset: data first
        mid_reset();
        d_kind = 2'b01; d_dm_addr = 32'h0000_0080; d_if_addr = 32'h0000_0044;
        if_want = 1; dm_want = 1;
        repeat (9) step();

        // store with both load and store raised
        d_kind = 2'b11; d_dm_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; dm_want = 1;
        repeat (5) step();

        // back-to-back held requests alternate
        d_kind = 2'b01; d_dm_addr = 32'h0000_0300; d_if_addr = 32'h0000_0048;
        if_want = 3; dm_want = 3;
        repeat (22) step();

        // reset during the first strobe cycle of a fetch
        d_if_addr = 32'h0000_004C; if_want = 1;
        step();
        step();
        mid_reset();
        repeat (6) step();

        // randomized traffic with occasional resets
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) mid_reset();
            else step();
        end
        rand_mode = 1'b0; if_want = 0; dm_want = 0;
        repeat (10) step();

        // MEM_LATENCY = 1 load on the second instance
        b_read_nxt = 1'b1;
        step();
        chk1("b_pipe_hold", pipe_hold_b, 1'b1);
        chk1("b_re_c0", mem_re_b, 1'b0);
        step();
        chk1("b_re_c1", mem_re_b, 1'b1);
        chk32("b_addr_c1", mem_addr_b, 32'h0000_0200);
        chk1("b_valid_c1", dm_valid_b, 1'b0);
        step();
        chk1("b_re_c2", mem_re_b, 1'b0);
        chk1("b_valid_c2", dm_valid_b, 1'b1);
        chk32("b_rdata_c2", dm_rdata_b, 32'h1234_5678);
        chk1("b_pipe_hold_c2", pipe_hold_b, 1'b0);
        b_read_nxt = 1'b0;
        step();
        chk1("b_valid_c3", dm_valid_b, 1'b0);
        chk32("b_rdata_c3", dm_rdata_b, 32'h1234_5678);
        chk1("b_re_c3", mem_re_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning memory access cycles per transaction (legal 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port if_req  input  1  instruction fetch request, held until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port dm_read  input  1  data load request (lw), held until dm_valid.
REQ-007 SHALL have port dm_write  input  1  data store request (sw), held until dm_valid.
REQ-008 SHALL have port dm_addr  input  32  data byte address.
REQ-009 SHALL have port dm_wdata  input  32  store data.
REQ-010 SHALL have port mem_rdata  input  32  read data from the single-ported unified memory.
REQ-011 SHALL have port mem_addr  output  32  memory address, registered.
REQ-012 SHALL have port mem_wdata  output  32  memory write data, registered.
REQ-013 SHALL have port mem_re / mem_we  output  1 each  memory read / write strobes, registered.
REQ-014 SHALL have port if_rdata / dm_rdata  output  32 each  returned instruction / load data, held between returns.
REQ-015 SHALL have port if_valid / dm_valid  output  1 each  one-cycle completion pulses.
REQ-016 SHALL have port pc_hold  output  1  freeze PC and IF/ID register.
REQ-017 SHALL have port pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB registers.

Function
REQ-018 SHALL implement FSM states IDLE, DATA, FETCH; a 3-bit down-counter cnt; a 1-bit last_grant (0=fetch, 1=data).
REQ-019 SHALL treat a request as pending only if asserted and its own valid is not high in that cycle.
REQ-020 In IDLE with only data pending: next state DATA, cnt<=MEM_LATENCY-1, mem_addr<=dm_addr, last_grant<=1.
REQ-021 In IDLE with only fetch pending: next state FETCH, cnt<=MEM_LATENCY-1, mem_addr<=if_addr, mem_re<=1, last_grant<=0.
REQ-022 In IDLE with both pending: data wins if last_grant=0, fetch wins if last_grant=1 (no starvation).
REQ-023 Data grant with dm_write=1 (read ignored if both high): mem_we<=1, mem_re<=0, mem_wdata<=dm_wdata; else mem_re<=1, mem_we<=0.
REQ-024 In DATA/FETCH with cnt>0: cnt decrements, mem_* held constant.
REQ-025 In DATA/FETCH with cnt=0: capture mem_rdata into dm_rdata (DATA read only) or if_rdata (FETCH); next cycle pulse matching valid; mem_re<=0, mem_we<=0; return to IDLE.
REQ-026 Latency: request first pending in cycle t -> strobes high cycles t+1..t+MEM_LATENCY -> valid high cycle t+MEM_LATENCY+1.
REQ-027 A store SHALL pulse dm_valid and SHALL leave dm_rdata unchanged.
REQ-028 New grant SHALL be made in the same cycle a valid pulses (IDLE arbitration), excluding the completing requester per REQ-019.
REQ-029 pipe_hold SHALL be combinational: (dm_read|dm_write) & ~dm_valid.
REQ-030 pc_hold SHALL be combinational: pipe_hold | (if_req & ~if_valid).
REQ-031 Address/data inputs changing after grant SHALL NOT affect the transaction in flight.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, cnt=0, last_grant=0, mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0, if_rdata=0, dm_rdata=0, if_valid=0, dm_valid=0.
REQ-033 Reset mid-transaction SHALL abort it with no valid pulse; after release the still-held request is re-arbitrated from IDLE.

Verification
REQ-034 MEM_LATENCY=2, if_req=1 if_addr=0x40, mem_rdata=0x8C010004 -> mem_re high 2 cycles, if_valid pulses cycle 3, if_rdata=0x8C010004, pc_hold high cycles 0..2.
REQ-035 dm_read and if_req both rise in same cycle after reset -> data granted first, pipe_hold and pc_hold high; fetch granted in dm_valid cycle.
REQ-036 dm_write=1 dm_read=1 dm_addr=0x100 dm_wdata=0xDEADBEEF -> mem_we=1 mem_re=0 mem_wdata=0xDEADBEEF for 2 cycles, dm_valid pulses, dm_rdata unchanged.
REQ-037 Back-to-back data and fetch requests held continuously -> grants alternate data/fetch/data; no requester waits more than one transaction.
REQ-038 rst_n pulsed low in cycle 1 of a FETCH -> all outputs 0 asynchronously, no if_valid; fetch restarts after release and completes MEM_LATENCY+1 cycles later.
REQ-039 MEM_LATENCY=1, dm_read with mem_rdata=0x12345678 -> mem_re one cycle, dm_valid next cycle, dm_rdata=0x12345678.
